// File: rtl/dd_pkg.sv
// Shared constants, types and helpers for the frame darkener.
//   - luma weights/shift, datapath widths
//   - mode encodings for mode_i
//   - saturating sum helper and threshold clamp
package dd_pkg;

    localparam int unsigned PIX_W      = 24;
    localparam int unsigned LUMA_W     = 8;
    localparam int unsigned LUMA_RAW_W = 11;
    localparam int unsigned SUM_W      = 30;
    localparam int unsigned CNT_W      = 22;

    localparam int unsigned W_R        = 2;
    localparam int unsigned W_G        = 5;
    localparam int unsigned W_B        = 1;
    localparam int unsigned LUMA_SHIFT = 3;

    typedef enum logic [1:0] {
        MODE_AUTO     = 2'b00,
        MODE_PASS     = 2'b01,
        MODE_INV      = 2'b10,
        MODE_AUTO_ALT = 2'b11
    } mode_e;

    function automatic logic [LUMA_W-1:0] clamp_luma(input int v);
        if (v < 0)   return '0;
        if (v > 255) return '1;
        return LUMA_W'(v);
    endfunction

    // Add a luma sample to the frame sum, sticking at all-ones.
    function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                     input logic [LUMA_W-1:0] b);
        logic [SUM_W:0] t;
        t = {1'b0, a} + (SUM_W+1)'(b);
        return t[SUM_W] ? '1 : t[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/frame_darkener_if.sv
// Video bundle between the frame delayer/source and the frame darkener.
//   inputs : vs_i, hs_i, de_i, live_data_i, dly_data_i, mode_i
//   outputs: vs_o, hs_o, de_o, data_o, dark_o
// master drives the *_i side, slave is the darkener.
interface frame_darkener_if;
    import dd_pkg::*;

    logic             vs_i;
    logic             hs_i;
    logic             de_i;
    logic [PIX_W-1:0] live_data_i;
    logic [PIX_W-1:0] dly_data_i;
    logic [1:0]       mode_i;

    logic             vs_o;
    logic             hs_o;
    logic             de_o;
    logic [PIX_W-1:0] data_o;
    logic             dark_o;

    modport master (
        output vs_i, hs_i, de_i, live_data_i, dly_data_i, mode_i,
        input  vs_o, hs_o, de_o, data_o, dark_o
    );

    modport slave (
        input  vs_i, hs_i, de_i, live_data_i, dly_data_i, mode_i,
        output vs_o, hs_o, de_o, data_o, dark_o
    );

endinterface

// File: rtl/frame_darkener_luma_acc.sv
// luma_acc: per-frame luma measurement for the frame darkener.
//   clk_i, rst_i  : pixel clock, async active-high reset
//   vs_i, de_i    : frame sync and pixel valid
//   live_data_i   : live pixel {R,G,B}
//   sum_o, pcnt_o : drained frame luma sum / pixel count (valid with eval_o)
//   eval_o        : frame-boundary strobe (vs rise, two pipeline stages late)
module luma_acc
    import dd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vs_i,
    input  logic             de_i,
    input  logic [PIX_W-1:0] live_data_i,
    output logic [SUM_W-1:0] sum_o,
    output logic [CNT_W-1:0] pcnt_o,
    output logic             eval_o
);

    logic                  vs_r_q, vs_r_d;
    logic                  vs_rise_d1_q, vs_rise_d1_d;
    logic [LUMA_W-1:0]     y_q, y_d;
    logic                  y_vld_q, y_vld_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [CNT_W-1:0]      pcnt_q, pcnt_d;
    logic                  vs_rise;
    logic [LUMA_RAW_W-1:0] luma_raw;

    always_comb begin
        vs_rise  = vs_i & ~vs_r_q;
        luma_raw = LUMA_RAW_W'(W_R) * LUMA_RAW_W'(live_data_i[23:16])
                 + LUMA_RAW_W'(W_G) * LUMA_RAW_W'(live_data_i[15:8])
                 + LUMA_RAW_W'(W_B) * LUMA_RAW_W'(live_data_i[7:0]);

        vs_r_d       = vs_i;
        vs_rise_d1_d = vs_rise;
        y_d          = LUMA_W'(luma_raw >> LUMA_SHIFT);
        y_vld_d      = de_i;

        // Stage-2 add is folded in combinationally: sum_o/pcnt_o already include
        // the sample in flight, so the frame is fully drained on the same edge
        // the re-timed vs_o rises. The sample after it lands on a cleared sum.
        sum_o  = y_vld_q ? sat_add_sum(sum_q, y_q) : sum_q;
        pcnt_o = (y_vld_q && (pcnt_q != '1)) ? pcnt_q + 1'b1 : pcnt_q;
        eval_o = vs_rise_d1_q;

        sum_d  = eval_o ? '0 : sum_o;
        pcnt_d = eval_o ? '0 : pcnt_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_r_q       <= 1'b0;
            vs_rise_d1_q <= 1'b0;
            y_q          <= '0;
            y_vld_q      <= 1'b0;
            sum_q        <= '0;
            pcnt_q       <= '0;
        end else begin
            vs_r_q       <= vs_r_d;
            vs_rise_d1_q <= vs_rise_d1_d;
            y_q          <= y_d;
            y_vld_q      <= y_vld_d;
            sum_q        <= sum_d;
            pcnt_q       <= pcnt_d;
        end
    end

endmodule

// File: rtl/frame_darkener.sv
// frame_darkener: inverts the delayed frame when the live frame it came from
// was bright (mean luma above threshold), otherwise passes it through.
//   clk_i, rst_i : pixel clock, async active-high reset
//   vid (slave)  : vs/hs/de, live and delayed pixels, mode in;
//                  syncs/data re-timed by 2 cycles, dark_o decision out
// Optional: define DARK_HYST_EN for a two-threshold (hysteresis) auto decision.
module frame_darkener
    import dd_pkg::*;
#(
    parameter int H_WIDTH  = 1920,
    parameter int V_HEIGHT = 1080,
    parameter int THRESH   = 128,
    parameter int HYST     = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    frame_darkener_if.slave    vid
);

    localparam bit CFG_OK = (longint'(H_WIDTH) * longint'(V_HEIGHT) <= (longint'(1) << CNT_W))
                         && (THRESH >= 0) && (THRESH <= 255) && (HYST >= 0);

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] pcnt;
    logic             eval;

    luma_acc u_luma_acc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .vs_i        (vid.vs_i),
        .de_i        (vid.de_i),
        .live_data_i (vid.live_data_i),
        .sum_o       (sum),
        .pcnt_o      (pcnt),
        .eval_o      (eval)
    );

`ifdef DARK_HYST_EN
    localparam logic [LUMA_W-1:0] THR_HI = clamp_luma(THRESH + HYST);
    localparam logic [LUMA_W-1:0] THR_LO = clamp_luma(THRESH - HYST);
    logic [SUM_W-1:0] prod_hi, prod_lo;
`else
    localparam logic [LUMA_W-1:0] THR = clamp_luma(THRESH);
    logic [SUM_W-1:0] prod;
`endif

    logic             auto_bright;
    logic             dec_q, dec_d;
    logic [PIX_W-1:0] d1_q, d1_d;
    logic             vs1_q, vs1_d, hs1_q, hs1_d, de1_q, de1_d;
    logic [PIX_W-1:0] data2_q, data2_d;
    logic             vs2_q, vs2_d, hs2_q, hs2_d, de2_q, de2_d;

    always_comb begin
`ifdef DARK_HYST_EN
        prod_hi     = SUM_W'(THR_HI) * SUM_W'(pcnt);
        prod_lo     = SUM_W'(THR_LO) * SUM_W'(pcnt);
        auto_bright = dec_q ? !(sum < prod_lo) : (sum > prod_hi);
`else
        prod        = SUM_W'(THR) * SUM_W'(pcnt);
        auto_bright = sum > prod;
`endif

        // Decision moves only at the boundary, together with the vs_o rise.
        dec_d = dec_q;
        if (eval) begin
            case (mode_e'(vid.mode_i))
                MODE_PASS: dec_d = 1'b0;
                MODE_INV:  dec_d = 1'b1;
                default:   if (pcnt != '0) dec_d = auto_bright;
            endcase
        end

        d1_d  = vid.dly_data_i;
        vs1_d = vid.vs_i;
        hs1_d = vid.hs_i;
        de1_d = vid.de_i;

        data2_d = de1_q ? (dec_q ? ~d1_q : d1_q) : '0;
        vs2_d   = vs1_q;
        hs2_d   = hs1_q;
        de2_d   = de1_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_q   <= 1'b0;
            d1_q    <= '0;
            vs1_q   <= 1'b0;
            hs1_q   <= 1'b0;
            de1_q   <= 1'b0;
            data2_q <= '0;
            vs2_q   <= 1'b0;
            hs2_q   <= 1'b0;
            de2_q   <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            d1_q    <= d1_d;
            vs1_q   <= vs1_d;
            hs1_q   <= hs1_d;
            de1_q   <= de1_d;
            data2_q <= data2_d;
            vs2_q   <= vs2_d;
            hs2_q   <= hs2_d;
            de2_q   <= de2_d;
        end
    end

    assign vid.vs_o   = vs2_q;
    assign vid.hs_o   = hs2_q;
    assign vid.de_o   = de2_q;
    assign vid.data_o = data2_q;
    assign vid.dark_o = dec_q;

    cfg_ok_a: assert property (@(posedge clk_i) CFG_OK);

endmodule

// File: tb/tb_frame_darkener.sv
// Scoreboard bench for frame_darkener (H_WIDTH=4, V_HEIGHT=2, THRESH=128).
module tb_frame_darkener;
    import dd_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int TH = 128;
    localparam int HY = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    frame_darkener_if vid();

    frame_darkener #(
        .H_WIDTH  (H),
        .V_HEIGHT (V),
        .THRESH   (TH),
        .HYST     (HY)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .vid   (vid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    logic [23:0] data_q[$];
    logic        dark_q[$];
    logic        model_dec = 1'b0;
    longint      m_sum = 0;
    longint      m_cnt = 0;

    function automatic int luma(input logic [23:0] p);
        return (2 * int'(p[23:16]) + 5 * int'(p[15:8]) + int'(p[7:0])) >> 3;
    endfunction

    task automatic eval_boundary(input logic [1:0] m);
        logic bright;
`ifdef DARK_HYST_EN
        int hi, lo;
        hi = (TH + HY > 255) ? 255 : TH + HY;
        lo = (TH - HY < 0) ? 0 : TH - HY;
        bright = model_dec ? !(m_sum < lo * m_cnt) : (m_sum > hi * m_cnt);
`else
        bright = m_sum > TH * m_cnt;
`endif
        case (m)
            2'b01:   model_dec = 1'b0;
            2'b10:   model_dec = 1'b1;
            default: if (m_cnt != 0) model_dec = bright;
        endcase
        m_sum = 0;
        m_cnt = 0;
        dark_q.push_back(model_dec);
    endtask

    task automatic drive(input logic vs, input logic hs, input logic de,
                         input logic [23:0] live, input logic [23:0] dly);
        vid.vs_i        = vs;
        vid.hs_i        = hs;
        vid.de_i        = de;
        vid.live_data_i = de ? live : 24'h0;
        vid.dly_data_i  = de ? dly : 24'h0;
        if (de) begin
            data_q.push_back(model_dec ? ~dly : dly);
            m_sum += luma(live);
            m_cnt++;
        end
        @(posedge clk_i);
        #1;
    endtask

    // One frame; abort_px > 0 asserts reset asynchronously after that many pixels.
    task automatic frame(input logic [23:0] live, input logic [23:0] dly, input bit use_de,
                         input logic [1:0] mid_mode, input int abort_px);
        int npx;
        npx = 0;
        eval_boundary(vid.mode_i);
        repeat (2) drive(1'b1, 1'b0, 1'b0, live, dly);
        repeat (3) drive(1'b0, 1'b0, 1'b0, live, dly);
        for (int l = 0; l < V; l++) begin
            drive(1'b0, 1'b1, 1'b0, live, dly);
            drive(1'b0, 1'b0, 1'b0, live, dly);
            for (int p = 0; p < H; p++) begin
                if (l == V - 1 && p == 0) vid.mode_i = mid_mode;
                drive(1'b0, 1'b0, use_de, live, dly);
                npx++;
                if (abort_px > 0 && npx == abort_px) begin
                    #1;
                    rst_i = 1'b1;
                    vid.vs_i = 1'b0; vid.hs_i = 1'b0; vid.de_i = 1'b0;
                    vid.live_data_i = 24'h0; vid.dly_data_i = 24'h0;
                    #1;
                    check("rst_vs_o",   32'(vid.vs_o),   32'd0);
                    check("rst_hs_o",   32'(vid.hs_o),   32'd0);
                    check("rst_de_o",   32'(vid.de_o),   32'd0);
                    check("rst_data_o", 32'(vid.data_o), 32'd0);
                    check("rst_dark_o", 32'(vid.dark_o), 32'd0);
                    data_q.delete();
                    dark_q.delete();
                    model_dec = 1'b0;
                    m_sum = 0;
                    m_cnt = 0;
                    repeat (2) @(posedge clk_i);
                    #3;
                    rst_i = 1'b0;
                    return;
                end
            end
            drive(1'b0, 1'b0, 1'b0, live, dly);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b0, live, dly);
    endtask

    // Expected sync outputs: inputs delayed by two clocks.
    logic [2:0] h1, h2;
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h1 <= 3'b0;
            h2 <= 3'b0;
        end else begin
            h1 <= {vid.vs_i, vid.hs_i, vid.de_i};
            h2 <= h1;
        end
    end

    logic vs_prev = 1'b0;
    always @(negedge clk_i) begin
        if (rst_i) begin
            vs_prev = 1'b0;
        end else begin
            check("syncs", 32'({vid.vs_o, vid.hs_o, vid.de_o}), 32'(h2));
            if (vid.de_o) begin
                if (data_q.size() == 0) check("sb_avail", 32'(data_q.size()), 32'd1);
                else check("data_o", 32'(vid.data_o), 32'(data_q.pop_front()));
            end else begin
                check("data_blank", 32'(vid.data_o), 32'd0);
            end
            if (vid.vs_o && !vs_prev) begin
                if (dark_q.size() == 0) check("dark_avail", 32'(dark_q.size()), 32'd1);
                else check("dark_o", 32'(vid.dark_o), 32'(dark_q.pop_front()));
            end
            vs_prev = vid.vs_o;
        end
    end

    initial begin
        vid.vs_i = 1'b0; vid.hs_i = 1'b0; vid.de_i = 1'b0;
        vid.live_data_i = 24'h0; vid.dly_data_i = 24'h0;
        vid.mode_i = 2'b00;
        #3;
        check("init_vs_o",   32'(vid.vs_o),   32'd0);
        check("init_hs_o",   32'(vid.hs_o),   32'd0);
        check("init_de_o",   32'(vid.de_o),   32'd0);
        check("init_data_o", 32'(vid.data_o), 32'd0);
        check("init_dark_o", 32'(vid.dark_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        frame(24'hFFFFFF, 24'h000000, 1'b1, 2'b00, 0);  // bright live, no prior decision
        frame(24'h000000, 24'h123456, 1'b1, 2'b00, 0);  // inverted: EDCBA9
        frame(24'h808080, 24'h123456, 1'b1, 2'b00, 0);  // black measured: pass
        frame(24'h8C8C8C, 24'h123456, 1'b1, 2'b00, 0);  // Y=128 measured: pass
        frame(24'h969696, 24'h123456, 1'b1, 2'b00, 0);  // Y=140 measured
        frame(24'h787878, 24'h123456, 1'b1, 2'b00, 0);  // Y=150 measured: invert
        frame(24'h000000, 24'h123456, 1'b1, 2'b10, 0);  // Y=120 measured; force inv mid-frame
        frame(24'h000000, 24'h123456, 1'b1, 2'b01, 0);  // forced invert on black
        frame(24'hFFFFFF, 24'h123456, 1'b1, 2'b00, 0);  // forced pass
        frame(24'h000000, 24'h123456, 1'b0, 2'b00, 0);  // bright measured; empty frame
        frame(24'hFFFFFF, 24'h123456, 1'b1, 2'b00, 0);  // empty measured: hold invert
        frame(24'hFFFFFF, 24'h123456, 1'b1, 2'b00, 3);  // inverting, reset mid-frame
        frame(24'hFFFFFF, 24'h000000, 1'b1, 2'b00, 0);  // nothing measured since reset
        frame(24'h000000, 24'h123456, 1'b1, 2'b00, 0);  // inverted: EDCBA9
        frame(24'h000000, 24'h123456, 1'b1, 2'b00, 0);  // black measured: pass

        repeat (6) drive(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        check("sb_drain",   32'(data_q.size()), 32'd0);
        check("dark_drain", 32'(dark_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
